// File: rtl/config_transmitter_pkg.sv
// config_tx_pkg: definitions shared by the configuration transmitter and the
// receivers' sanity checks.
//   tx_state_e             - transmitter session state (trace / gap / send)
//   DEFAULT_IDLE_CONFIG_ID - bus ID driven when no frame is on the bus; no block
//                            may own it
package config_tx_pkg;

  localparam logic [7:0] DEFAULT_IDLE_CONFIG_ID = 8'hFF;

  typedef enum logic [1:0] {
    StTrace,
    StGap,
    StSend
  } tx_state_e;

  // Byte k of a firmware word, byte 0 in the least significant bits.
  function automatic logic [7:0] frame_byte(logic [255:0] data, int unsigned k);
    return data[8*k +: 8];
  endfunction

endpackage

// File: rtl/config_transmitter_if.sv
// config_transmitter_if: host-side frame handshake, trace-stream boundary
// inputs and the reconfiguration bus of config_transmitter.
//   frame_valid/frame_ready/frame_config_id/frame_data - frame push handshake
//   start                                               - reconfiguration request
//   valid_in/eof_in                                     - trace stream at pipeline entry
//   tracing/configId/configData                         - reconfiguration bus
//   busy/cfg_error                                      - status
// master: the host / environment side. slave: the transmitter.
interface config_transmitter_if #(
  parameter int unsigned MAX_CHAINS = 4
);

  logic                    frame_valid;
  logic                    frame_ready;
  logic [7:0]              frame_config_id;
  logic [8*MAX_CHAINS-1:0] frame_data;
  logic                    start;
  logic                    valid_in;
  logic                    eof_in;
  logic                    tracing;
  logic [7:0]              configId;
  logic [7:0]              configData;
  logic                    busy;
  logic                    cfg_error;

  modport master (
    output frame_valid,
    output frame_config_id,
    output frame_data,
    output start,
    output valid_in,
    output eof_in,
    input  frame_ready,
    input  tracing,
    input  configId,
    input  configData,
    input  busy,
    input  cfg_error
  );

  modport slave (
    input  frame_valid,
    input  frame_config_id,
    input  frame_data,
    input  start,
    input  valid_in,
    input  eof_in,
    output frame_ready,
    output tracing,
    output configId,
    output configData,
    output busy,
    output cfg_error
  );

endinterface

// File: rtl/config_frame_fifo.sv
// config_frame_fifo: FIFO of configuration frames {id, data}.
//   clk, rst          - clock, asynchronous active-high reset (flushes the FIFO)
//   push, push_id,
//   push_data         - write one frame (ignored when full)
//   pop               - drop the head frame (ignored when empty)
//   full, empty       - occupancy flags derived from the pointers
//   count             - number of stored frames
//   head_id,
//   head_data         - oldest frame, valid when !empty
module config_frame_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_id,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 head_id,
  output logic [DATA_W-1:0]          head_data
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [7:0]        id_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // One extra pointer bit distinguishes full from empty when the addresses match.
  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
            (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    count = wr_ptr_q - rd_ptr_q;

    do_push = push && !full;
    do_pop  = pop && !empty;

    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    head_id   = id_mem[rd_ptr_q[AddrW-1:0]];
    head_data = data_mem[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      id_mem[wr_ptr_q[AddrW-1:0]]   <= push_id;
      data_mem[wr_ptr_q[AddrW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/config_transmitter.sv
// config_transmitter: buffers host configuration frames and, on request,
// suspends tracing at a trace-frame boundary and serialises each frame onto
// the reconfiguration bus as MAX_CHAINS consecutive bytes under one configId,
// each frame preceded by a single idle-ID gap cycle that resets the receivers'
// byte counters.
//   clk  - clock
//   rst  - asynchronous active-high reset; flushes the FIFO mid-session
//   bus  - config_transmitter_if.slave: frame handshake, start, trace-stream
//          boundary inputs, config bus outputs, busy and sticky cfg_error
// All outputs are registered except frame_ready.
module config_transmitter
  import config_tx_pkg::*;
#(
  parameter int unsigned MAX_CHAINS     = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [7:0]  IDLE_CONFIG_ID = DEFAULT_IDLE_CONFIG_ID
) (
  input logic                 clk,
  input logic                 rst,
  config_transmitter_if.slave bus
);

  localparam int unsigned DataW = 8 * MAX_CHAINS;
  localparam int unsigned IdxW  = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(MAX_CHAINS - 1);

  // FIFO interface
  logic             fifo_full;
  logic             fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [7:0]       head_id;
  logic [DataW-1:0] head_data;
  logic             push;
  logic             pop;
  logic             push_fire;
  logic             id_is_idle;

  // Control state
  tx_state_e       state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            cfg_error_q, cfg_error_d;

  // Output registers
  logic            tracing_q, tracing_d;
  logic            busy_q, busy_d;
  logic [7:0]      config_id_q, config_id_d;
  logic [7:0]      config_data_q, config_data_d;

  config_frame_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DataW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_id   (bus.frame_config_id),
    .push_data (bus.frame_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_id   (head_id),
    .head_data (head_data)
  );

  // No bypass: a pop in the full cycle does not raise ready until the next cycle.
  assign bus.frame_ready = !fifo_full;

  always_comb begin
    push_fire  = bus.frame_valid && !fifo_full;
    id_is_idle = (bus.frame_config_id == IDLE_CONFIG_ID);
    // A frame aimed at the idle ID is consumed but never stored.
    push        = push_fire && !id_is_idle;
    cfg_error_d = cfg_error_q || (push_fire && id_is_idle);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    // start is folded in immediately so a request sampled at a safe point
    // enters the gap on the very next cycle, and a start during a session is
    // remembered for later.
    pending_d = pending_q || bus.start;

    unique case (state_q)
      StTrace: begin
        if (pending_d && !fifo_empty && (bus.eof_in || !bus.valid_in)) begin
          state_d   = StGap;
          pending_d = 1'b0;
        end
      end
      StGap: begin
        state_d = StSend;
        idx_d   = '0;
      end
      StSend: begin
        if (idx_q == IdxLast) begin
          pop   = 1'b1;
          idx_d = '0;
          // After the pop, anything left (or arriving now) goes in this session.
          if ((fifo_count > CntW'(1)) || push) begin
            state_d = StGap;
          end else begin
            state_d = StTrace;
          end
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StTrace;
    endcase
  end

  // Outputs are computed from the next state so they line up with state_q.
  always_comb begin
    tracing_d     = (state_d == StTrace);
    busy_d        = (state_d != StTrace);
    config_id_d   = IDLE_CONFIG_ID;
    config_data_d = 8'h00;
    if (state_d == StSend) begin
      config_id_d   = head_id;
      config_data_d = head_data[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StTrace;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      cfg_error_q   <= 1'b0;
      tracing_q     <= 1'b1;
      busy_q        <= 1'b0;
      config_id_q   <= IDLE_CONFIG_ID;
      config_data_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      cfg_error_q   <= cfg_error_d;
      tracing_q     <= tracing_d;
      busy_q        <= busy_d;
      config_id_q   <= config_id_d;
      config_data_q <= config_data_d;
    end
  end

  assign bus.tracing    = tracing_q;
  assign bus.busy       = busy_q;
  assign bus.configId   = config_id_q;
  assign bus.configData = config_data_q;
  assign bus.cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_config_transmitter.sv
// Self-checking bench for config_transmitter. Inputs are driven and outputs
// sampled on the falling edge; expected bus activity comes from a frame-level
// model: each queued frame costs one idle gap cycle plus MAX_CHAINS byte cycles.
module tb_config_transmitter;

  localparam int unsigned MC = 4;
  localparam int unsigned FL = MC + 1;
  localparam logic [7:0]  IDLE = 8'hFF;

  typedef struct {
    logic [7:0]      id;
    logic [8*MC-1:0] data;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_transmitter_if #(.MAX_CHAINS(MC)) bus ();

  config_transmitter #(
    .MAX_CHAINS     (MC),
    .FIFO_DEPTH     (4),
    .IDLE_CONFIG_ID (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  frame_t q[$];

  // Receiver model: counts bytes from 0 while its ID is on the bus.
  logic [7:0] rx_id = 8'h03;
  logic [7:0] rx_fw [MC];
  int         rx_cnt = 0;
  always @(posedge clk) begin
    if (!bus.tracing && bus.configId == rx_id) begin
      if (rx_cnt < MC) rx_fw[rx_cnt] <= bus.configData;
      rx_cnt <= rx_cnt + 1;
    end else begin
      rx_cnt <= 0;
    end
  end

  // Expected {tracing, configId, configData} c cycles after the start edge.
  function automatic logic [16:0] exp_out(int c);
    int f = c / FL;
    int r = c % FL;
    if (f >= q.size()) return {1'b1, IDLE, 8'h00};
    if (r == 0) return {1'b0, IDLE, 8'h00};
    return {1'b0, q[f].id, q[f].data[8*(r-1) +: 8]};
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.id   = 8'($urandom_range(0, 254));
    f.data = $urandom;
    return f;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    bus.frame_valid = 1'b0; bus.frame_config_id = '0; bus.frame_data = '0;
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.eof_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_frame(input frame_t f);
    bus.frame_valid = 1'b1;
    bus.frame_config_id = f.id;
    bus.frame_data = f.data;
    @(negedge clk);
    bus.frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({bus.tracing, bus.configId, bus.configData, bus.busy, bus.frame_ready, bus.cfg_error}
          !== {1'b1, IDLE, 8'h00, 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got t=%b id=%h d=%h busy=%b rdy=%b err=%b", i,
                 bus.tracing, bus.configId, bus.configData, bus.busy, bus.frame_ready,
                 bus.cfg_error);
      end
    end
  endtask

  task automatic test_single();
    frame_t f;
    logic [16:0] e;
    reset_dut();
    q.delete();
    rx_id = 8'h03;
    f.id = 8'h03; f.data = 32'h44332211;
    q.push_back(f);
    push_frame(f);
    bus.start = 1'b1;
    for (int c = 0; c <= FL; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_out(c);
      total++;
      if ({bus.tracing, bus.configId, bus.configData, bus.busy} !== {e, ~e[16]}) begin
        bad++;
        $display("FAIL single c=%0d got=%b_%h_%h_%b exp=%b_%h_%h_%b", c, bus.tracing,
                 bus.configId, bus.configData, bus.busy, e[16], e[15:8], e[7:0], ~e[16]);
      end
    end
    total++;
    if ({rx_fw[3], rx_fw[2], rx_fw[1], rx_fw[0]} !== 32'h44332211) begin
      bad++;
      $display("FAIL single_rx got=%h exp=44332211", {rx_fw[3], rx_fw[2], rx_fw[1], rx_fw[0]});
    end
  endtask

  task automatic test_boundary();
    frame_t f;
    logic [16:0] e;
    reset_dut();
    q.delete();
    f = rand_frame();
    q.push_back(f);
    push_frame(f);
    bus.valid_in = 1'b1;
    bus.eof_in = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.tracing, bus.configId} !== {1'b1, IDLE}) begin
        bad++;
        $display("FAIL boundary_wait cyc=%0d got t=%b id=%h exp t=1 id=ff", i, bus.tracing,
                 bus.configId);
      end
    end
    bus.eof_in = 1'b1;
    for (int c = 0; c <= FL; c++) begin
      @(negedge clk);
      bus.eof_in = 1'b0;
      bus.valid_in = 1'b0;
      e = exp_out(c);
      total++;
      if ({bus.tracing, bus.configId, bus.configData} !== e) begin
        bad++;
        $display("FAIL boundary_send c=%0d got=%b_%h_%h exp=%b_%h_%h", c, bus.tracing,
                 bus.configId, bus.configData, e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t fa, fb;
    logic [16:0] e;
    int low = 0;
    reset_dut();
    q.delete();
    rx_id = 8'h00;
    fa = rand_frame(); fa.id = 8'h00;
    fb = rand_frame(); fb.id = 8'h00;
    q.push_back(fa); q.push_back(fb);
    push_frame(fa);
    push_frame(fb);
    bus.start = 1'b1;
    for (int c = 0; c <= 2 * FL + 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.tracing) low++;
      e = exp_out(c);
      total++;
      if ({bus.tracing, bus.configId, bus.configData} !== e) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b_%h_%h exp=%b_%h_%h", c, bus.tracing, bus.configId,
                 bus.configData, e[16], e[15:8], e[7:0]);
      end
    end
    total++;
    if (low != 2 * FL) begin
      bad++;
      $display("FAIL b2b_len got=%0d exp=%0d", low, 2 * FL);
    end
    total++;
    if ({rx_fw[3], rx_fw[2], rx_fw[1], rx_fw[0]} !== fb.data) begin
      bad++;
      $display("FAIL b2b_rx got=%h exp=%h", {rx_fw[3], rx_fw[2], rx_fw[1], rx_fw[0]}, fb.data);
    end
  endtask

  task automatic test_full_error();
    frame_t f;
    logic [16:0] e;
    reset_dut();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      f = rand_frame();
      q.push_back(f);
      push_frame(f);
    end
    total++;
    if (bus.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b exp=0", bus.frame_ready);
    end
    // Fifth frame offered while full: must not be taken.
    push_frame(rand_frame());
    total++;
    if (bus.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_hold got=%b exp=0", bus.frame_ready);
    end
    bus.start = 1'b1;
    for (int c = 0; c <= 4 * FL; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_out(c);
      total++;
      if ({bus.tracing, bus.configId, bus.configData} !== e) begin
        bad++;
        $display("FAIL full_send c=%0d got=%b_%h_%h exp=%b_%h_%h", c, bus.tracing,
                 bus.configId, bus.configData, e[16], e[15:8], e[7:0]);
      end
      if (c == MC || c == FL) begin
        total++;
        if (bus.frame_ready !== (c == FL)) begin
          bad++;
          $display("FAIL full_pop_ready c=%0d got=%b exp=%b", c, bus.frame_ready, c == FL);
        end
      end
    end
    q.delete();
    f = rand_frame();
    f.id = IDLE;
    push_frame(f);
    total++;
    if (bus.cfg_error !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b exp=1", bus.cfg_error);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.tracing, bus.configId, bus.busy, bus.cfg_error} !== {1'b1, IDLE, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL err_not_sent cyc=%0d got t=%b id=%h busy=%b err=%b", i, bus.tracing,
                 bus.configId, bus.busy, bus.cfg_error);
      end
    end
  endtask

  task automatic test_random();
    frame_t f, fx;
    logic [16:0] e;
    int n, extra;
    reset_dut();
    for (int it = 0; it < 5; it++) begin
      q.delete();
      n = $urandom_range(1, 3);
      extra = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        f = rand_frame();
        q.push_back(f);
        push_frame(f);
      end
      fx = rand_frame();
      if (extra != 0) q.push_back(fx);
      bus.start = 1'b1;
      for (int c = 0; c <= (n + extra) * FL; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        e = exp_out(c);
        total++;
        if ({bus.tracing, bus.configId, bus.configData} !== e) begin
          bad++;
          $display("FAIL random it=%0d c=%0d got=%b_%h_%h exp=%b_%h_%h", it, c, bus.tracing,
                   bus.configId, bus.configData, e[16], e[15:8], e[7:0]);
        end
        bus.frame_valid = 1'b0;
        if (extra != 0 && c == 2) begin
          bus.frame_valid = 1'b1;
          bus.frame_config_id = fx.id;
          bus.frame_data = fx.data;
        end
        // Trace-stream activity is irrelevant once the session has started.
        bus.valid_in = (c < (n + extra) * FL) ? 1'($urandom) : 1'b0;
      end
      bus.valid_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_send();
    frame_t f;
    logic [16:0] e;
    reset_dut();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      f = rand_frame();
      q.push_back(f);
      push_frame(f);
    end
    bus.start = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_out(c);
      total++;
      if ({bus.tracing, bus.configId, bus.configData} !== e) begin
        bad++;
        $display("FAIL midrst_pre c=%0d got=%b_%h_%h exp=%b_%h_%h", c, bus.tracing,
                 bus.configId, bus.configData, e[16], e[15:8], e[7:0]);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.tracing, bus.configId, bus.configData, bus.busy, bus.frame_ready, bus.cfg_error}
        !== {1'b1, IDLE, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_async got t=%b id=%h d=%h busy=%b rdy=%b err=%b", bus.tracing,
               bus.configId, bus.configData, bus.busy, bus.frame_ready, bus.cfg_error);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.tracing, bus.configId, bus.configData, bus.busy} !== {1'b1, IDLE, 8'h00, 1'b0})
      begin
        bad++;
        $display("FAIL midrst_flushed cyc=%0d got t=%b id=%h d=%h busy=%b", i, bus.tracing,
                 bus.configId, bus.configData, bus.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_full_error();
    test_random();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_transmitter.md
# config_transmitter

Drives the debugger's reconfiguration bus (`tracing`, `configId`, `configData`) that every building block listens to. It buffers host-supplied configuration frames, each a block ID plus MAX_CHAINS firmware bytes. On request, it suspends tracing at a safe point, serializes each frame as a run of consecutive bytes under a constant `configId`, then resumes tracing. It sits at the top level, upstream of all instrumented blocks.

## Interface
- MAX_CHAINS, 4: firmware bytes per frame, matching the receivers' MAX_CHAINS.
- FIFO_DEPTH, 4: frames buffered; power of two, ≥2.
- IDLE_CONFIG_ID, 8'hFF: ID driven when no frame is being sent; no block may own it.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- frame_valid  in  1  host frame offered.
- frame_ready  out  1  frame accepted when valid&&ready.
- frame_config_id  in  8  target block ID.
- frame_data  in  8*MAX_CHAINS  firmware; byte k = bits [8k+7:8k], sent k-th.
- start  in  1  one-cycle reconfiguration request.
- valid_in  in  1  trace-stream valid at pipeline entry.
- eof_in  in  1  trace-stream end-of-frame.
- tracing  out  1  1 = normal tracing, 0 = reconfiguring.
- configId  out  8  config bus ID.
- configData  out  8  config bus byte.
- busy  out  1  high while not in TRACE.
- cfg_error  out  1  sticky; a frame with ID == IDLE_CONFIG_ID was offered.

## Operation
- All outputs are registered except `frame_ready` = !fifo_full.
- Reset values: tracing=1, configId=IDLE_CONFIG_ID, configData=0, busy=0, cfg_error=0. The FIFO is empty and the pending flag is clear.
- Push: on valid&&ready, the frame is written to the FIFO. If frame_config_id==IDLE_CONFIG_ID, the frame is consumed but not stored, and cfg_error is set.
- No push bypass when full: ready stays low in the full cycle even if a pop occurs.
- `start` sets `pending`. A start while busy is absorbed into the current session, with pending set again; the start is never lost.
- States:
  - TRACE: tracing=1, configId=IDLE_CONFIG_ID, configData=0. Go to GAP when pending && !fifo_empty && (eof_in || !valid_in); clear pending on that transition. With pending and an empty FIFO, stay in TRACE and keep pending.
  - GAP: tracing=0, configId=IDLE_CONFIG_ID, configData=0 for exactly one cycle. This resets every receiver's byte counter. Then go to SEND with idx=0.
  - SEND: tracing=0, configId=head.id, configData=head.byte[idx]. Increment idx each cycle. After idx==MAX_CHAINS-1, pop the head. If the FIFO is then non-empty, go to GAP; otherwise go to TRACE.
- Frames pushed during a session are sent in the same session.
- Consecutive frames with the same ID are separated by the GAP cycle, so the receiver restarts at byte 0.
- Async reset mid-session returns all outputs to reset values immediately and flushes the FIFO. Receivers keep their partially written firmware; the host must resend.

## Timing
- start sampled at edge t with conditions met: from t+1, tracing=0 and configId=IDLE (GAP).
- Edges t+2 … t+1+MAX_CHAINS: bytes 0…MAX_CHAINS-1 of frame 0.
- Each frame costs MAX_CHAINS+1 cycles. n frames occupy t+1 … t+n·(MAX_CHAINS+1).
- tracing=1 from edge t+n·(MAX_CHAINS+1)+1.
- Receiver writes byte k into firmware[k] on the k-th cycle of the run, since it counts from 0 under the matching ID.
- Pop takes effect at the edge after the last byte. frame_ready can rise in the cycle following that edge.

## Structure
- Package `config_tx_pkg`: state enum {TRACE, GAP, SEND} and default IDLE_CONFIG_ID constant (8'hFF), shared with the receivers' sanity assertions.
- Sub-module `config_frame_fifo`:
  - FIFO of {id, data}, FIFO_DEPTH entries.
  - Pointers one bit wider than the address; full/empty derived from the pointers.
  - Async reset.
- Top: FSM, idx counter ($clog2(MAX_CHAINS) bits), pending/error flags, output registers.

## Test plan
- Reset/idle: release rst, no stimulus → tracing=1, configId=8'hFF, configData=0, busy=0, frame_ready=1 indefinitely.
- Single frame: push id=3, data=32'h44332211, start with valid_in=0 → one GAP cycle (FF), then configId=3 with data 11,22,33,44 on four consecutive cycles, then tracing=1. An attached vectorScalar-reduce receiver with ID 3 holds firmware {11,22,33,44}.
- Boundary wait: start while valid_in=1, eof_in=0 for 10 cycles → tracing stays 1. Pulse eof_in → GAP on the next cycle.
- Back-to-back same ID: push id=0 twice (data A, B), then start → id 0 bytes A, an FF gap, id 0 bytes B. The receiver ends with B in every slot. Total 10 cycles with tracing=0.
- FIFO full and error: push 5 frames with no start → frame_ready drops after the 4th. Offer id=FF → cfg_error=1 and the frame is not sent.
- Reset mid-SEND: assert rst after byte 1 → outputs return to reset values in the same cycle, FIFO empty. A subsequent start does nothing.
